// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the sync_fifo read-side stream engine.
package fifo_pkg;

    localparam int WIDTH_DEF  = 8;
    localparam int RD_LAT_DEF = 1;
    localparam int BEAT_CNT_W = 16;

    // Number of bits needed to hold an index or count below 'depth'.
    // Returns at least 1, so that a single-entry structure still gets a
    // real signal.
    function automatic int clog2_depth(input int depth);
        int w;
        w = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < depth) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/stream_obuf.sv
// Circular output buffer. It holds words that have returned from the FIFO
// but have not yet been accepted downstream.
module stream_obuf
    import fifo_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DEPTH = 3
) (
    input  logic                                  clk_i,
    input  logic                                  rst_i,
    input  logic                                  push_i,
    input  logic [WIDTH-1:0]                      push_data_i,
    input  logic                                  pop_i,
    output logic [clog2_depth(DEPTH + 1)-1:0]     occ_o,
    output logic [WIDTH-1:0]                      head_data_o
);

    localparam int PTR_W = clog2_depth(DEPTH);
    localparam int OCC_W = clog2_depth(DEPTH + 1);
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(DEPTH - 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [OCC_W-1:0] occ_q, occ_d;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_IDX) ? '0 : p + 1'b1;
    endfunction

    // Next-state for storage, pointers and occupancy; a simultaneous push and pop leaves occupancy unchanged.
    always_comb begin
        mem_d  = mem_q;
        head_d = head_q;
        tail_d = tail_q;
        occ_d  = occ_q;
        if (push_i) begin
            mem_d[tail_q] = push_data_i;
            tail_d        = ptr_inc(tail_q);
        end
        if (pop_i) begin
            head_d = ptr_inc(head_q);
        end
        if (push_i && !pop_i) begin
            occ_d = occ_q + 1'b1;
        end else if (!push_i && pop_i) begin
            occ_d = occ_q - 1'b1;
        end
    end

    // State registers; storage is cleared so that the head word reads as zero after reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            head_q <= '0;
            tail_q <= '0;
            occ_q  <= '0;
        end else begin
            mem_q  <= mem_d;
            head_q <= head_d;
            tail_q <= tail_d;
            occ_q  <= occ_d;
        end
    end

    // The issue logic upstream must never let a push land in a full buffer without a pop in the same cycle.
    always @(posedge clk_i) begin
        if (!rst_i) begin
            assert (!(push_i && !pop_i && occ_q == OCC_W'(DEPTH)));
        end
    end

    assign occ_o       = occ_q;
    assign head_data_o = mem_q[head_q];

endmodule

// File: rtl/sync_fifo_rd_stream.sv
// Read-side engine for sync_fifo. It pops the FIFO, absorbs its fixed read
// latency, and presents the words as a framed valid/ready stream. Reads are
// issued only when a buffer slot is guaranteed, so m_ready_i never reaches
// fifo_rd_en_o combinationally. A reset drops any buffered or in-flight words.
module sync_fifo_rd_stream
    import fifo_pkg::*;
#(
    parameter int WIDTH   = WIDTH_DEF,
    parameter int RD_LAT  = RD_LAT_DEF,
    parameter int PKT_LEN = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  en_i,
    input  logic                  fifo_empty_i,
    output logic                  fifo_rd_en_o,
    input  logic [WIDTH-1:0]      fifo_rdata_i,
    output logic                  m_valid_o,
    input  logic                  m_ready_i,
    output logic [WIDTH-1:0]      m_data_o,
    output logic                  m_last_o,
    output logic                  busy_o,
    output logic [BEAT_CNT_W-1:0] beat_cnt_o
);

    localparam int BUF_DEPTH = RD_LAT + 2;
    localparam int OCC_W     = clog2_depth(BUF_DEPTH + 1);
    localparam logic [BEAT_CNT_W-1:0] LAST_BEAT = BEAT_CNT_W'(PKT_LEN - 1);

    logic [RD_LAT-1:0]     infl_q, infl_d;
    logic [BEAT_CNT_W-1:0] beat_cnt_q, beat_cnt_d;
    logic [OCC_W-1:0]      occ;
    logic [OCC_W-1:0]      infl_cnt;
    logic [OCC_W:0]        pending;
    logic                  push;
    logic                  pop;
    logic [WIDTH-1:0]      head_data;

    // Count of outstanding reads, and the issue decision taken from registered state only.
    always_comb begin
        infl_cnt = '0;
        for (int k = 0; k < RD_LAT; k++) begin
            infl_cnt = infl_cnt + OCC_W'(infl_q[k]);
        end
        pending      = {1'b0, occ} + {1'b0, infl_cnt};
        fifo_rd_en_o = en_i && !fifo_empty_i && (pending < (OCC_W + 1)'(BUF_DEPTH));
    end

    // In-flight shift register and packet beat counter next-state.
    always_comb begin
        infl_d    = '0;
        infl_d[0] = fifo_rd_en_o;
        for (int k = 1; k < RD_LAT; k++) begin
            infl_d[k] = infl_q[k-1];
        end
        beat_cnt_d = beat_cnt_q;
        if (pop) begin
            beat_cnt_d = (beat_cnt_q == LAST_BEAT) ? '0 : beat_cnt_q + 1'b1;
        end
    end

    // State registers for the read pipe and beat counter.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            infl_q     <= '0;
            beat_cnt_q <= '0;
        end else begin
            infl_q     <= infl_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    assign push = infl_q[RD_LAT-1];
    assign pop  = m_valid_o && m_ready_i;

    stream_obuf #(
        .WIDTH (WIDTH),
        .DEPTH (BUF_DEPTH)
    ) u_obuf (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .push_i      (push),
        .push_data_i (fifo_rdata_i),
        .pop_i       (pop),
        .occ_o       (occ),
        .head_data_o (head_data)
    );

    assign m_valid_o  = (occ != '0);
    assign m_data_o   = head_data;
    assign m_last_o   = m_valid_o && (beat_cnt_q == LAST_BEAT);
    assign busy_o     = m_valid_o || (infl_q != '0);
    assign beat_cnt_o = beat_cnt_q;

endmodule
